// File: rtl/core_rrv_dmem_resp.sv
// Data-memory responder for the rrv core: local SRAM window with zero stall,
// everything else through a valid/ready fabric port that freezes the core while in flight.
module core_rrv_dmem_resp #(
    parameter logic [31:0] LOCAL_BASE = 32'h0001_0000,
    parameter int unsigned LOCAL_AW   = 12,
    parameter logic [7:0]  TIMEOUT    = 8'd255
) (
    input  logic                Clock,
    input  logic                Rst,
    input  logic [31:0]         DMemAddrQ103H,
    input  logic [31:0]         DMemWrDataQ103H,
    input  logic                DMemWrEnQ103H,
    input  logic                DMemRdEnQ103H,
    input  logic [3:0]          DMemByteEnQ103H,
    output logic                DMemReady,
    output logic [31:0]         DMemRdDataQ104H,
    output logic [LOCAL_AW-1:0] LocalAddr,
    output logic                LocalRdEn,
    output logic                LocalWrEn,
    output logic [3:0]          LocalByteEn,
    output logic [31:0]         LocalWrData,
    input  logic [31:0]         LocalRdData,
    output logic                FabReqValid,
    input  logic                FabReqReady,
    output logic                FabReqWr,
    output logic [31:0]         FabReqAddr,
    output logic [31:0]         FabReqData,
    output logic [3:0]          FabReqByteEn,
    input  logic                FabRspValid,
    input  logic [31:0]         FabRspData,
    output logic                FabRspReady,
    output logic                ErrTimeout,
    output logic                ErrMisalign
);

    localparam logic [32:0] WIN_BYTES = 33'd4 << LOCAL_AW;

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] rel;
    logic        is_local;
    logic        req;
    logic        remote;
    logic [1:0]  off;
    logic [6:0]  be_shift;
    logic [3:0]  lane_be;
    logic        misalign;
    logic [31:0] lane_wr_data;
    logic [7:0]  cnt;
    logic [8:0]  cnt_inc;
    logic        tmo;
    logic        timeout_hit;
    logic        capture;
    logic        dmem_ready;
    logic        fab_req_valid;
    logic        fab_rsp_ready;
    logic        fab_wr;
    logic [31:0] fab_addr;
    logic [31:0] fab_data;
    logic [3:0]  fab_be;
    logic [31:0] rsp_reg;
    logic        err_timeout;
    logic        sel_remote_q104h;
    logic [1:0]  off_q104h;
    logic [31:0] rd_src;

    // Request decode: the subtraction wraps addresses below the base out of the window.
    assign rel          = DMemAddrQ103H - LOCAL_BASE;
    assign is_local     = ({1'b0, rel} < WIN_BYTES);
    assign req          = DMemWrEnQ103H | DMemRdEnQ103H;
    assign remote       = req & ~is_local;
    assign off          = DMemAddrQ103H[1:0];
    assign be_shift     = {3'b000, DMemByteEnQ103H} << off;
    assign lane_be      = be_shift[3:0];
    assign misalign     = |be_shift[6:4];
    assign lane_wr_data = DMemWrDataQ103H << {off, 3'b000};

    assign cnt_inc = {1'b0, cnt} + 9'd1;
    assign tmo     = (cnt_inc >= {1'b0, TIMEOUT});

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        timeout_hit   = 1'b0;
        capture       = 1'b0;
        dmem_ready    = 1'b0;
        fab_req_valid = 1'b0;
        fab_rsp_ready = 1'b1;
        case (state)
            IDLE: begin
                dmem_ready = ~remote;
                if (remote) state_next = REQ;
            end
            REQ: begin
                fab_req_valid = 1'b1;
                fab_rsp_ready = 1'b0;
                // An accepted request wins over a simultaneous timeout so the fabric is never orphaned.
                if (FabReqReady) begin
                    state_next = RSP;
                end else if (tmo) begin
                    state_next  = DONE;
                    timeout_hit = 1'b1;
                end
            end
            RSP: begin
                if (FabRspValid) begin
                    state_next = DONE;
                    capture    = 1'b1;
                end else if (tmo) begin
                    state_next  = DONE;
                    timeout_hit = 1'b1;
                end
            end
            DONE: begin
                dmem_ready = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            cnt              <= '0;
            fab_wr           <= 1'b0;
            fab_addr         <= '0;
            fab_data         <= '0;
            fab_be           <= '0;
            rsp_reg          <= '0;
            err_timeout      <= 1'b0;
            sel_remote_q104h <= 1'b0;
            off_q104h        <= '0;
        end else begin
            err_timeout <= timeout_hit;
            if (state == IDLE) begin
                cnt <= '0;
                if (remote) begin
                    fab_wr   <= DMemWrEnQ103H;
                    fab_addr <= {DMemAddrQ103H[31:2], 2'b00};
                    fab_data <= lane_wr_data;
                    fab_be   <= lane_be;
                end
            end else if (state == REQ || state == RSP) begin
                cnt <= cnt_inc[7:0];
            end
            if (capture && !fab_wr) begin
                rsp_reg <= FabRspData;
            end else if (timeout_hit) begin
                rsp_reg <= 32'hDEAD_BEEF;
            end
            // Q104H select only advances with the core, so frozen cycles keep the old result.
            if (dmem_ready) begin
                sel_remote_q104h <= remote;
                off_q104h        <= off;
            end
        end
    end

    assign rd_src          = sel_remote_q104h ? rsp_reg : LocalRdData;
    assign DMemRdDataQ104H = rd_src >> {off_q104h, 3'b000};

    assign DMemReady    = dmem_ready;
    assign LocalAddr    = rel[LOCAL_AW+1:2];
    assign LocalRdEn    = DMemRdEnQ103H & ~DMemWrEnQ103H & is_local & dmem_ready;
    assign LocalWrEn    = DMemWrEnQ103H & is_local & dmem_ready;
    assign LocalByteEn  = lane_be;
    assign LocalWrData  = lane_wr_data;
    assign FabReqValid  = fab_req_valid;
    assign FabReqWr     = fab_wr;
    assign FabReqAddr   = fab_addr;
    assign FabReqData   = fab_data;
    assign FabReqByteEn = fab_be;
    assign FabRspReady  = fab_rsp_ready;
    assign ErrTimeout   = err_timeout;
    assign ErrMisalign  = dmem_ready & req & misalign;

endmodule

// File: tb/tb_core_rrv_dmem_resp.sv
// Directed bench for core_rrv_dmem_resp: behavioural SRAM plus a scripted fabric.
module tb_core_rrv_dmem_resp;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        Clock = 1'b0;
    logic        Rst;
    logic [31:0] DMemAddrQ103H;
    logic [31:0] DMemWrDataQ103H;
    logic        DMemWrEnQ103H;
    logic        DMemRdEnQ103H;
    logic [3:0]  DMemByteEnQ103H;
    logic        DMemReady;
    logic [31:0] DMemRdDataQ104H;
    logic [11:0] LocalAddr;
    logic        LocalRdEn;
    logic        LocalWrEn;
    logic [3:0]  LocalByteEn;
    logic [31:0] LocalWrData;
    logic [31:0] LocalRdData = 32'hA5A5_0F0F;
    logic        FabReqValid;
    logic        FabReqReady;
    logic        FabReqWr;
    logic [31:0] FabReqAddr;
    logic [31:0] FabReqData;
    logic [3:0]  FabReqByteEn;
    logic        FabRspValid;
    logic [31:0] FabRspData;
    logic        FabRspReady;
    logic        ErrTimeout;
    logic        ErrMisalign;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:4095];

    core_rrv_dmem_resp dut (
        .Clock(Clock), .Rst(Rst),
        .DMemAddrQ103H(DMemAddrQ103H), .DMemWrDataQ103H(DMemWrDataQ103H),
        .DMemWrEnQ103H(DMemWrEnQ103H), .DMemRdEnQ103H(DMemRdEnQ103H),
        .DMemByteEnQ103H(DMemByteEnQ103H), .DMemReady(DMemReady),
        .DMemRdDataQ104H(DMemRdDataQ104H), .LocalAddr(LocalAddr),
        .LocalRdEn(LocalRdEn), .LocalWrEn(LocalWrEn), .LocalByteEn(LocalByteEn),
        .LocalWrData(LocalWrData), .LocalRdData(LocalRdData),
        .FabReqValid(FabReqValid), .FabReqReady(FabReqReady), .FabReqWr(FabReqWr),
        .FabReqAddr(FabReqAddr), .FabReqData(FabReqData), .FabReqByteEn(FabReqByteEn),
        .FabRspValid(FabRspValid), .FabRspData(FabRspData), .FabRspReady(FabRspReady),
        .ErrTimeout(ErrTimeout), .ErrMisalign(ErrMisalign)
    );

    always #5 Clock = ~Clock;

    // 1-cycle SRAM whose output holds when not read.
    always @(posedge Clock) begin
        if (LocalRdEn) LocalRdData <= mem[LocalAddr];
        if (LocalWrEn)
            for (int b = 0; b < 4; b++)
                if (LocalByteEn[b]) mem[LocalAddr][8*b +: 8] <= LocalWrData[8*b +: 8];
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_req(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be);
        DMemWrEnQ103H   = wr;
        DMemRdEnQ103H   = rd;
        DMemAddrQ103H   = addr;
        DMemWrDataQ103H = data;
        DMemByteEnQ103H = be;
    endtask

    task automatic set_idle();
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
    endtask

    // Drives the fabric side of one remote access on scripted cycles and records what it saw.
    task automatic run_remote(input int rdy_c, input int rsp_c, input int stale_c,
                              input logic [31:0] rsp_data, input int max_c,
                              output int stalls, output bit done, output int to_pulses,
                              output logic [31:0] f_addr, output logic [31:0] f_data,
                              output logic [3:0] f_be, output logic f_wr, output logic f_valid,
                              output logic [31:0] q_first, output bit q_moved);
        stalls = 0; done = 0; to_pulses = 0; q_moved = 0; q_first = '0;
        f_addr = '0; f_data = '0; f_be = '0; f_wr = 1'b0; f_valid = 1'b0;
        for (int c = 0; c < max_c && !done; c++) begin
            FabReqReady = (c == rdy_c);
            FabRspValid = (c == rsp_c) || (c == stale_c);
            FabRspData  = (c == rsp_c) ? rsp_data : 32'h5555_5555;
            @(negedge Clock);
            if (c == 0) q_first = DMemRdDataQ104H;
            else if (!DMemReady && DMemRdDataQ104H !== q_first) q_moved = 1;
            if (c == 1) begin
                f_addr = FabReqAddr; f_data = FabReqData; f_be = FabReqByteEn;
                f_wr = FabReqWr; f_valid = FabReqValid;
            end
            if (ErrTimeout) to_pulses++;
            if (DMemReady) done = 1; else stalls++;
            tick();
        end
        FabReqReady = 1'b0;
        FabRspValid = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        set_idle();
        FabReqReady = 1'b0; FabRspValid = 1'b0; FabRspData = 32'h0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        checks++; if (DMemReady !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", DMemReady); end
        checks++; if (FabReqValid !== 1'b0) begin failures++; $display("FAIL rst_reqvalid got=%b exp=0", FabReqValid); end
        checks++; if ({ErrTimeout, ErrMisalign, LocalWrEn, LocalRdEn} !== 4'b0000) begin failures++; $display("FAIL rst_strobes got=%b exp=0000", {ErrTimeout, ErrMisalign, LocalWrEn, LocalRdEn}); end
        checks++; if (FabRspReady !== 1'b1) begin failures++; $display("FAIL rst_rspready got=%b exp=1", FabRspReady); end
        checks++; if (DMemRdDataQ104H !== 32'hA5A5_0F0F) begin failures++; $display("FAIL rst_q104 got=%h exp=a5a50f0f", DMemRdDataQ104H); end
        Rst = 1'b1;
        tick();
        @(negedge Clock);
        checks++; if (DMemReady !== 1'b1) begin failures++; $display("FAIL rel_ready got=%b exp=1", DMemReady); end
    endtask

    task automatic test_local_load();
        tick();
        set_req(1'b1, 1'b0, BASE + 32'd8, 32'h1234_5678, 4'b1111);
        @(negedge Clock);
        checks++; if ({LocalWrEn, LocalRdEn, LocalAddr} !== {2'b10, 12'd2}) begin failures++; $display("FAIL sw_strobes got=%b/%b/%0d exp=1/0/2", LocalWrEn, LocalRdEn, LocalAddr); end
        tick();
        // Both enables high must behave as a store.
        set_req(1'b1, 1'b1, BASE, 32'h0, 4'b1111);
        @(negedge Clock);
        checks++; if ({LocalWrEn, LocalRdEn, DMemReady} !== 3'b101) begin failures++; $display("FAIL wr_rd_both got=%b exp=101", {LocalWrEn, LocalRdEn, DMemReady}); end
        tick();
        set_req(1'b0, 1'b1, BASE + 32'd8, 32'h0, 4'b1111);
        @(negedge Clock);
        checks++; if (DMemReady !== 1'b1) begin failures++; $display("FAIL lw_ready got=%b exp=1", DMemReady); end
        checks++; if ({LocalRdEn, LocalWrEn, LocalAddr} !== {2'b10, 12'd2}) begin failures++; $display("FAIL lw_strobes got=%b/%b/%0d exp=1/0/2", LocalRdEn, LocalWrEn, LocalAddr); end
        tick();
        set_req(1'b0, 1'b1, BASE + 32'd10, 32'h0, 4'b0011);
        @(negedge Clock);
        checks++; if (DMemRdDataQ104H !== 32'h1234_5678) begin failures++; $display("FAIL lw_data got=%h exp=12345678", DMemRdDataQ104H); end
        checks++; if (LocalByteEn !== 4'b1100) begin failures++; $display("FAIL lh_be got=%b exp=1100", LocalByteEn); end
        tick();
        set_idle();
        @(negedge Clock);
        checks++; if (DMemRdDataQ104H !== 32'h0000_1234) begin failures++; $display("FAIL lh_data got=%h exp=00001234", DMemRdDataQ104H); end
    endtask

    task automatic test_local_store_byte();
        tick();
        set_req(1'b1, 1'b0, BASE + 32'd3, 32'h0000_00AB, 4'b0001);
        @(negedge Clock);
        checks++; if (LocalByteEn !== 4'b1000) begin failures++; $display("FAIL sb_be got=%b exp=1000", LocalByteEn); end
        checks++; if (LocalWrData !== 32'hAB00_0000) begin failures++; $display("FAIL sb_data got=%h exp=ab000000", LocalWrData); end
        checks++; if ({DMemReady, LocalWrEn, ErrMisalign, LocalAddr} !== {3'b110, 12'd0}) begin failures++; $display("FAIL sb_ctl got=%b/%b/%b/%0d exp=1/1/0/0", DMemReady, LocalWrEn, ErrMisalign, LocalAddr); end
        tick();
        set_req(1'b0, 1'b1, BASE, 32'h0, 4'b1111);
        tick();
        set_idle();
        @(negedge Clock);
        checks++; if (DMemRdDataQ104H !== 32'hAB00_0000) begin failures++; $display("FAIL sb_readback got=%h exp=ab000000", DMemRdDataQ104H); end
    endtask

    task automatic test_remote_load();
        int stalls, to_p; bit done, moved;
        logic [31:0] fa, fd, qf; logic [3:0] fb; logic fw, fv;
        tick();
        set_req(1'b0, 1'b1, 32'h8000_0002, 32'h0, 4'b0011);
        run_remote(3, 4, -1, 32'hBEEF_0000, 20, stalls, done, to_p, fa, fd, fb, fw, fv, qf, moved);
        set_idle();
        checks++; if (done !== 1'b1 || stalls != 5) begin failures++; $display("FAIL lh_stalls got=%0d done=%b exp=5", stalls, done); end
        checks++; if ({fv, fw} !== 2'b10 || fa !== 32'h8000_0000) begin failures++; $display("FAIL lh_req got=v%b w%b %h exp=v1 w0 80000000", fv, fw, fa); end
        checks++; if (fb !== 4'b1100) begin failures++; $display("FAIL lh_fab_be got=%b exp=1100", fb); end
        checks++; if (moved !== 1'b0) begin failures++; $display("FAIL lh_q104_stable got=moved exp=stable"); end
        @(negedge Clock);
        checks++; if (DMemRdDataQ104H !== 32'h0000_BEEF) begin failures++; $display("FAIL lh_data got=%h exp=0000beef", DMemRdDataQ104H); end
    endtask

    task automatic test_timeout();
        int stalls, to_p; bit done, moved;
        logic [31:0] fa, fd, qf; logic [3:0] fb; logic fw, fv;
        tick();
        set_req(1'b1, 1'b0, 32'h8000_0010, 32'h1122_3344, 4'b1111);
        run_remote(1, -1, -1, 32'h0, 400, stalls, done, to_p, fa, fd, fb, fw, fv, qf, moved);
        set_idle();
        checks++; if (done !== 1'b1 || stalls != 256) begin failures++; $display("FAIL to_stalls got=%0d done=%b exp=256", stalls, done); end
        checks++; if (to_p != 1) begin failures++; $display("FAIL to_pulse got=%0d exp=1", to_p); end
        checks++; if ({fv, fw} !== 2'b11 || fd !== 32'h1122_3344 || fa !== 32'h8000_0010) begin failures++; $display("FAIL sw_req got=v%b w%b %h %h exp=v1 w1 80000010 11223344", fv, fw, fa, fd); end
        // Late response lands in IDLE and must be swallowed.
        FabRspValid = 1'b1; FabRspData = 32'h7777_7777;
        @(negedge Clock);
        checks++; if (DMemRdDataQ104H !== 32'hDEAD_BEEF) begin failures++; $display("FAIL to_data got=%h exp=deadbeef", DMemRdDataQ104H); end
        checks++; if ({ErrTimeout, DMemReady, FabRspReady} !== 3'b011) begin failures++; $display("FAIL late_rsp got=%b exp=011", {ErrTimeout, DMemReady, FabRspReady}); end
        tick();
        FabRspValid = 1'b0;
        set_req(1'b0, 1'b1, 32'h8000_0004, 32'h0, 4'b1111);
        run_remote(1, 2, 0, 32'hCAFE_F00D, 20, stalls, done, to_p, fa, fd, fb, fw, fv, qf, moved);
        set_idle();
        checks++; if (done !== 1'b1 || stalls != 3) begin failures++; $display("FAIL min_stalls got=%0d done=%b exp=3", stalls, done); end
        @(negedge Clock);
        checks++; if (DMemRdDataQ104H !== 32'hCAFE_F00D) begin failures++; $display("FAIL stale_discard got=%h exp=cafef00d", DMemRdDataQ104H); end
    endtask

    task automatic test_reset_mid_op();
        int stalls, to_p; bit done, moved;
        logic [31:0] fa, fd, qf; logic [3:0] fb; logic fw, fv;
        tick();
        set_req(1'b0, 1'b1, 32'h8000_0020, 32'h0, 4'b1111);
        FabReqReady = 1'b0;
        tick();
        @(negedge Clock);
        checks++; if (FabReqValid !== 1'b1) begin failures++; $display("FAIL mid_req_valid got=%b exp=1", FabReqValid); end
        #2 Rst = 1'b0;
        #1;
        checks++; if ({FabReqValid, FabRspReady} !== 2'b01) begin failures++; $display("FAIL async_rst got=%b exp=01", {FabReqValid, FabRspReady}); end
        set_idle();
        @(negedge Clock);
        Rst = 1'b1;
        tick();
        @(negedge Clock);
        checks++; if ({DMemReady, FabReqValid, FabRspReady} !== 3'b101) begin failures++; $display("FAIL post_rst got=%b exp=101", {DMemReady, FabReqValid, FabRspReady}); end
        tick();
        set_req(1'b0, 1'b1, 32'h8000_0024, 32'h0, 4'b1111);
        run_remote(1, 2, 0, 32'h0102_0304, 20, stalls, done, to_p, fa, fd, fb, fw, fv, qf, moved);
        set_idle();
        checks++; if (done !== 1'b1 || stalls != 3) begin failures++; $display("FAIL post_rst_stalls got=%0d done=%b exp=3", stalls, done); end
    endtask

    task automatic test_window_boundary();
        int stalls, to_p; bit done, moved;
        logic [31:0] fa, fd, qf; logic [3:0] fb; logic fw, fv;
        tick();
        set_req(1'b0, 1'b1, BASE + 32'h3FFC, 32'h0, 4'b1111);
        @(negedge Clock);
        checks++; if ({DMemReady, LocalRdEn, LocalAddr} !== {2'b11, 12'hFFF}) begin failures++; $display("FAIL win_top got=%b/%b/%h exp=1/1/fff", DMemReady, LocalRdEn, LocalAddr); end
        tick();
        set_req(1'b0, 1'b1, BASE - 32'd4, 32'h0, 4'b1111);
        @(negedge Clock);
        checks++; if ({DMemReady, LocalRdEn} !== 2'b00) begin failures++; $display("FAIL win_below got=%b exp=00", {DMemReady, LocalRdEn}); end
        set_req(1'b0, 1'b1, BASE + 32'h4000, 32'h0, 4'b1111);
        run_remote(1, 2, -1, 32'h0F0F_F0F0, 20, stalls, done, to_p, fa, fd, fb, fw, fv, qf, moved);
        set_idle();
        checks++; if (done !== 1'b1 || stalls != 3 || fa !== 32'h0001_4000) begin failures++; $display("FAIL win_above got=%0d %h exp=3 00014000", stalls, fa); end
    endtask

    task automatic test_back_to_back();
        int stalls, to_p; bit done, moved;
        logic [31:0] fa, fd, qf; logic [3:0] fb; logic fw, fv;
        tick();
        set_req(1'b0, 1'b1, BASE + 32'd1, 32'h0, 4'b1111);
        @(negedge Clock);
        checks++; if ({ErrMisalign, LocalRdEn, DMemReady} !== 3'b111) begin failures++; $display("FAIL misalign_ctl got=%b exp=111", {ErrMisalign, LocalRdEn, DMemReady}); end
        checks++; if (LocalByteEn !== 4'b1110) begin failures++; $display("FAIL misalign_be got=%b exp=1110", LocalByteEn); end
        tick();
        set_req(1'b0, 1'b1, 32'h8000_0008, 32'h0, 4'b1111);
        run_remote(1, 2, -1, 32'h0BAD_CAFE, 20, stalls, done, to_p, fa, fd, fb, fw, fv, qf, moved);
        set_idle();
        checks++; if (qf !== 32'h00AB_0000) begin failures++; $display("FAIL misalign_data got=%h exp=00ab0000", qf); end
        checks++; if (moved !== 1'b0) begin failures++; $display("FAIL frozen_q104 got=moved exp=stable"); end
        checks++; if (done !== 1'b1 || stalls != 3) begin failures++; $display("FAIL b2b_stalls got=%0d done=%b exp=3", stalls, done); end
        @(negedge Clock);
        checks++; if (DMemRdDataQ104H !== 32'h0BAD_CAFE || ErrMisalign !== 1'b0) begin failures++; $display("FAIL b2b_data got=%h err=%b exp=0badcafe err=0", DMemRdDataQ104H, ErrMisalign); end
    endtask

    initial begin
        test_reset();
        test_local_load();
        test_local_store_byte();
        test_remote_load();
        test_timeout();
        test_reset_mid_op();
        test_window_boundary();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
